countdown: RTL and testbench
============================

Name: countdown

Overview:
Countdown timer that mirrors the stopwatch by counting in the opposite direction. A preset value in hours/mins/secs/msecs is loaded, counted down at one step per Clock_1MSec edge, and Alarm is raised when the count reaches zero. It sits beside the stopwatch, is clocked by the 1 ms output of clock_gen, and drives the same display path.

Parameters:
MSEC_MAX, 999, top value of the msecs field; the borrow reload value.
SEC_MAX, 59, top value of the secs and mins fields; the borrow reload value.
ALARM_LEN, 1000, number of Clock_1MSec cycles Alarm stays high (1 s).

Ports:
Clock_1MSec  input  1  1 kHz timer clock; all state changes on its rising edge.
Reset  input  1  asynchronous, active-high; clears all state.
Load_T  input  1  level; captures the preset into the count and the preset register.
Start_T  input  1  level; begins or resumes counting.
Stop_T  input  1  level; pauses counting.
Hours_In  input  4  preset hours, 0-15.
Mins_In  input  6  preset mins; values above SEC_MAX are clamped to SEC_MAX.
Secs_In  input  6  preset secs; values above SEC_MAX are clamped to SEC_MAX.
MSecs_In  input  10  preset msecs; values above MSEC_MAX are clamped to MSEC_MAX.
Hours_T  output  4  current hours.
Mins_T  output  6  current mins.
Secs_T  output  6  current secs.
MSecs_T  output  10  current msecs.
Running  output  1  high in state RUN.
Alarm  output  1  high for ALARM_LEN cycles after the count reaches zero.

Behaviour:
- Clock and reset: one clock, Clock_1MSec. Reset is asynchronous and active-high; it forces state IDLE and drives every output to 0, including the preset register and the alarm counter.
- States are IDLE, RUN, PAUSE and DONE. All outputs are registered.
- Input priority each cycle: Load_T > Stop_T > Start_T.
- Load_T in any state:
  - Count and preset are set to the clamped inputs.
  - State goes to IDLE; Alarm and the alarm counter clear.
  - Takes effect on the same edge; visible on the outputs next cycle.
- IDLE:
  - Start_T with count nonzero goes to RUN. The first decrement happens on the next edge, not the Start edge.
  - Start_T with count equal to 0 is ignored; state stays IDLE.
- RUN: each edge decrements the count by 1 ms.
  - If MSecs=0: it reloads to MSEC_MAX and borrows from Secs.
  - If Secs=0 on a borrow: it reloads to SEC_MAX and borrows from Mins.
  - If Mins=0 on a borrow: it reloads to SEC_MAX and borrows from Hours.
  - Hours never underflows, because a zero count exits RUN first.
  - Stop_T goes to PAUSE; the count holds on that edge with no decrement.
  - Start_T held high in RUN has no effect.
- Reaching zero (RUN with count 0:0:0:1):
  - On that edge the count becomes 0:0:0:0, state becomes DONE, and Alarm rises, all together.
  - Running falls on the same edge.
- PAUSE: count holds. Start_T returns to RUN; Stop_T has no effect.
- DONE:
  - Count holds at 0.
  - Alarm stays high for exactly ALARM_LEN cycles, counted from the edge it rose, then falls and state goes to IDLE.
  - Start_T and Stop_T are ignored; Load_T aborts the alarm immediately.
- Simultaneous inputs: Start_T and Stop_T together resolve as Stop_T. Load_T with either one resolves as Load_T.
- Reset mid-count or mid-alarm: everything returns to 0 immediately, without waiting for a clock edge.

Optional Feature:
AUTO_RELOAD_EN:
- Defined: when RUN reaches zero, the count reloads from the preset register on the same edge. State stays RUN, Running stays high, and Alarm pulses high for 1 cycle; ALARM_LEN is unused. A zero preset still blocks Start_T.
- Undefined: DONE and alarm-timing behaviour exactly as described above. No preset register is needed beyond the count itself.

Test Plan:
- Borrow chain: Reset, then Load 0:0:0:3, then Start. Count goes 0:0:0:2, then 0:0:0:1, then 0:0:0:0 with Running=0 and Alarm=1. Alarm stays high 1000 cycles, then state is IDLE.
- Full borrow: Load 1:0:0:0, then Start. One edge later outputs are 0:59:59:999.
- Clamp and pause: Load Mins=63, Secs=60, MSecs=1023 reads back 0:59:59:999. Start for 5 cycles, then Stop for 10 cycles: count holds at 0:59:59:994. Start again and counting resumes.
- Priority: Load_T=Start_T=Stop_T=1 together leaves state IDLE with the new preset. Start_T=Stop_T=1 in RUN goes to PAUSE.
- Zero and reset: Start with count 0 leaves state IDLE and Alarm=0. Reset asserted asynchronously mid-RUN at 0:0:5:500 clears all outputs to 0 before the next edge.
- AUTO_RELOAD_EN defined: Load 0:0:0:2, then Start. Count goes 2, 1, then reloads to 2 with a 1-cycle Alarm pulse, and Running stays 1.

Source files
------------

// File: rtl/countdown_if.sv
//==============================================================================
// Module      : countdown_if
// Description : Control, preset and count/status bundle of the countdown timer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface countdown_if;
    logic       Load_T;
    logic       Start_T;
    logic       Stop_T;
    logic [3:0] Hours_In;
    logic [5:0] Mins_In;
    logic [5:0] Secs_In;
    logic [9:0] MSecs_In;
    logic [3:0] Hours_T;
    logic [5:0] Mins_T;
    logic [5:0] Secs_T;
    logic [9:0] MSecs_T;
    logic       Running;
    logic       Alarm;

    modport master (
        output Load_T, Start_T, Stop_T, Hours_In, Mins_In, Secs_In, MSecs_In,
        input  Hours_T, Mins_T, Secs_T, MSecs_T, Running, Alarm
    );

    modport slave (
        input  Load_T, Start_T, Stop_T, Hours_In, Mins_In, Secs_In, MSecs_In,
        output Hours_T, Mins_T, Secs_T, MSecs_T, Running, Alarm
    );
endinterface

`default_nettype wire

// File: rtl/countdown.sv
//==============================================================================
// Module      : countdown
// Description : Hours/mins/secs/msecs countdown timer with a timed alarm,
//               stepped by the 1 ms clock. Optional macro AUTO_RELOAD_EN
//               restarts from the preset on zero with a 1-cycle alarm pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module countdown #(
    parameter int MSEC_MAX  = 999,
    parameter int SEC_MAX   = 59,
    parameter int ALARM_LEN = 1000
) (
    input  wire logic  Clock_1MSec,
    input  wire logic  Reset,
    countdown_if.slave bus
);

    localparam logic [9:0] c_msec_max = 10'(MSEC_MAX);
    localparam logic [5:0] c_sec_max  = 6'(SEC_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q,   state_d;
    logic [3:0] hours_q,   hours_d;
    logic [5:0] mins_q,    mins_d;
    logic [5:0] secs_q,    secs_d;
    logic [9:0] msecs_q,   msecs_d;
    logic       running_q, running_d;
    logic       alarm_q,   alarm_d;

`ifdef AUTO_RELOAD_EN
    logic [3:0] p_hours_q, p_hours_d;
    logic [5:0] p_mins_q,  p_mins_d;
    logic [5:0] p_secs_q,  p_secs_d;
    logic [9:0] p_msecs_q, p_msecs_d;
`else
    localparam int                  c_acnt_w     = $clog2(ALARM_LEN + 1);
    localparam logic [c_acnt_w-1:0] c_alarm_last = c_acnt_w'(ALARM_LEN - 1);

    logic [c_acnt_w-1:0] acnt_q, acnt_d;
`endif

    logic [5:0] w_mins_in;
    logic [5:0] w_secs_in;
    logic [9:0] w_msecs_in;
    logic       w_count_zero;
    logic       w_count_one;

    always_comb begin
        w_mins_in  = (bus.Mins_In  > c_sec_max)  ? c_sec_max  : bus.Mins_In;
        w_secs_in  = (bus.Secs_In  > c_sec_max)  ? c_sec_max  : bus.Secs_In;
        w_msecs_in = (bus.MSecs_In > c_msec_max) ? c_msec_max : bus.MSecs_In;
        w_count_zero = (hours_q == 4'd0) && (mins_q == 6'd0) &&
                       (secs_q == 6'd0) && (msecs_q == 10'd0);
        w_count_one  = (hours_q == 4'd0) && (mins_q == 6'd0) &&
                       (secs_q == 6'd0) && (msecs_q == 10'd1);
    end

    always_comb begin
        state_d = state_q;
        hours_d = hours_q;
        mins_d  = mins_q;
        secs_d  = secs_q;
        msecs_d = msecs_q;
`ifdef AUTO_RELOAD_EN
        p_hours_d = p_hours_q;
        p_mins_d  = p_mins_q;
        p_secs_d  = p_secs_q;
        p_msecs_d = p_msecs_q;
        // Alarm is only ever a single-cycle pulse in this mode.
        alarm_d   = 1'b0;
`else
        acnt_d    = acnt_q;
        alarm_d   = alarm_q;
`endif

        if (bus.Load_T) begin
            hours_d = bus.Hours_In;
            mins_d  = w_mins_in;
            secs_d  = w_secs_in;
            msecs_d = w_msecs_in;
            state_d = S_IDLE;
            alarm_d = 1'b0;
`ifdef AUTO_RELOAD_EN
            p_hours_d = bus.Hours_In;
            p_mins_d  = w_mins_in;
            p_secs_d  = w_secs_in;
            p_msecs_d = w_msecs_in;
`else
            acnt_d    = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start_T && !bus.Stop_T && !w_count_zero) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.Stop_T) begin
                        state_d = S_PAUSE;
                    end else if (w_count_one) begin
`ifdef AUTO_RELOAD_EN
                        hours_d = p_hours_q;
                        mins_d  = p_mins_q;
                        secs_d  = p_secs_q;
                        msecs_d = p_msecs_q;
                        alarm_d = 1'b1;
`else
                        msecs_d = 10'd0;
                        state_d = S_DONE;
                        alarm_d = 1'b1;
                        acnt_d  = c_alarm_last;
`endif
                    end else if (msecs_q != 10'd0) begin
                        msecs_d = msecs_q - 10'd1;
                    end else begin
                        // Ripple borrow; RUN never holds a zero count, so hours cannot wrap.
                        msecs_d = c_msec_max;
                        if (secs_q != 6'd0) begin
                            secs_d = secs_q - 6'd1;
                        end else begin
                            secs_d = c_sec_max;
                            if (mins_q != 6'd0) begin
                                mins_d = mins_q - 6'd1;
                            end else begin
                                mins_d  = c_sec_max;
                                hours_d = hours_q - 4'd1;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.Start_T && !bus.Stop_T) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
`ifdef AUTO_RELOAD_EN
                    state_d = S_IDLE;
`else
                    if (acnt_q == '0) begin
                        alarm_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        acnt_d = acnt_q - 1'b1;
                    end
`endif
                end
            endcase
        end

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge Clock_1MSec or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            hours_q   <= 4'd0;
            mins_q    <= 6'd0;
            secs_q    <= 6'd0;
            msecs_q   <= 10'd0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
`ifdef AUTO_RELOAD_EN
            p_hours_q <= 4'd0;
            p_mins_q  <= 6'd0;
            p_secs_q  <= 6'd0;
            p_msecs_q <= 10'd0;
`else
            acnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hours_q   <= hours_d;
            mins_q    <= mins_d;
            secs_q    <= secs_d;
            msecs_q   <= msecs_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
`ifdef AUTO_RELOAD_EN
            p_hours_q <= p_hours_d;
            p_mins_q  <= p_mins_d;
            p_secs_q  <= p_secs_d;
            p_msecs_q <= p_msecs_d;
`else
            acnt_q    <= acnt_d;
`endif
        end
    end

    assign bus.Hours_T = hours_q;
    assign bus.Mins_T  = mins_q;
    assign bus.Secs_T  = secs_q;
    assign bus.MSecs_T = msecs_q;
    assign bus.Running = running_q;
    assign bus.Alarm   = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown.sv
//==============================================================================
// Module      : tb_countdown
// Description : Self-checking bench for countdown; reference keeps the count
//               as a single millisecond total.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_countdown;
    localparam int MSEC_MAX  = 999;
    localparam int SEC_MAX   = 59;
    localparam int ALARM_LEN = 1000;
    localparam int MS_H = 3600000;
    localparam int MS_M = 60000;
    localparam int MS_S = 1000;
    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_PAUSE = 2;
    localparam int MD_DONE  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;

    countdown_if bus();

    countdown #(
        .MSEC_MAX (MSEC_MAX),
        .SEC_MAX  (SEC_MAX),
        .ALARM_LEN(ALARM_LEN)
    ) dut (
        .Clock_1MSec(clk),
        .Reset      (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int m_total;
    int m_preset;
    int m_mode;
    int m_alarm_left;

    function automatic int clampv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_total      = 0;
            m_preset     = 0;
            m_mode       = MD_IDLE;
            m_alarm_left = 0;
        end else begin
`ifdef AUTO_RELOAD_EN
            m_alarm_left = 0;
`endif
            if (bus.Load_T) begin
                m_total = int'(bus.Hours_In) * MS_H
                        + clampv(int'(bus.Mins_In), SEC_MAX) * MS_M
                        + clampv(int'(bus.Secs_In), SEC_MAX) * MS_S
                        + clampv(int'(bus.MSecs_In), MSEC_MAX);
                m_preset     = m_total;
                m_mode       = MD_IDLE;
                m_alarm_left = 0;
            end else begin
                case (m_mode)
                    MD_IDLE:  if (bus.Start_T && !bus.Stop_T && m_total > 0) m_mode = MD_RUN;
                    MD_RUN: begin
                        if (bus.Stop_T) begin
                            m_mode = MD_PAUSE;
                        end else begin
                            m_total = m_total - 1;
                            if (m_total == 0) begin
`ifdef AUTO_RELOAD_EN
                                m_total      = m_preset;
                                m_alarm_left = 1;
`else
                                m_mode       = MD_DONE;
                                m_alarm_left = ALARM_LEN;
`endif
                            end
                        end
                    end
                    MD_PAUSE: if (bus.Start_T && !bus.Stop_T) m_mode = MD_RUN;
                    default: begin
                        m_alarm_left = m_alarm_left - 1;
                        if (m_alarm_left == 0) m_mode = MD_IDLE;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hours",   int'(bus.Hours_T), m_total / MS_H);
            check("mins",    int'(bus.Mins_T),  (m_total / MS_M) % 60);
            check("secs",    int'(bus.Secs_T),  (m_total / MS_S) % 60);
            check("msecs",   int'(bus.MSecs_T), m_total % 1000);
            check("running", int'(bus.Running), (m_mode == MD_RUN) ? 1 : 0);
            check("alarm",   int'(bus.Alarm),   (m_alarm_left > 0) ? 1 : 0);
        end
    end

    task automatic expect_now(input string tag, input int h, input int m, input int s,
                              input int ms, input int run, input int alm);
        check({tag, ".hours"},   int'(bus.Hours_T), h);
        check({tag, ".mins"},    int'(bus.Mins_T),  m);
        check({tag, ".secs"},    int'(bus.Secs_T),  s);
        check({tag, ".msecs"},   int'(bus.MSecs_T), ms);
        check({tag, ".running"}, int'(bus.Running), run);
        check({tag, ".alarm"},   int'(bus.Alarm),   alm);
    endtask

    task automatic drive(input bit ld, input bit st, input bit sp,
                         input int h, input int m, input int s, input int ms);
        bus.Load_T   = ld;
        bus.Start_T  = st;
        bus.Stop_T   = sp;
        bus.Hours_In = 4'(h);
        bus.Mins_In  = 6'(m);
        bus.Secs_In  = 6'(s);
        bus.MSecs_In = 10'(ms);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        int r, h, m, s, ms;
        bit ld, st, sp;

        bus.Load_T   = 1'b0;
        bus.Start_T  = 1'b0;
        bus.Stop_T   = 1'b0;
        bus.Hours_In = '0;
        bus.Mins_In  = '0;
        bus.Secs_In  = '0;
        bus.MSecs_In = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        expect_now("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

`ifndef AUTO_RELOAD_EN
        drive(1, 0, 0, 0, 0, 0, 3);  expect_now("load3", 0, 0, 0, 3, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);  expect_now("start3", 0, 0, 0, 3, 1, 0);
        idle(1);                     expect_now("dec2", 0, 0, 0, 2, 1, 0);
        idle(1);                     expect_now("dec1", 0, 0, 0, 1, 1, 0);
        idle(1);                     expect_now("zero", 0, 0, 0, 0, 0, 1);
        drive(0, 1, 1, 0, 0, 0, 0);
        idle(ALARM_LEN - 2);         expect_now("alarm_last", 0, 0, 0, 0, 0, 1);
        idle(1);                     expect_now("alarm_off", 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);  expect_now("zero_start", 0, 0, 0, 0, 0, 0);

        drive(1, 0, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        idle(1);                     expect_now("borrow", 0, 59, 59, 999, 1, 0);
`else
        drive(1, 0, 0, 0, 0, 0, 2);
        drive(0, 1, 0, 0, 0, 0, 0);  expect_now("ar_start", 0, 0, 0, 2, 1, 0);
        idle(1);                     expect_now("ar_dec1", 0, 0, 0, 1, 1, 0);
        idle(1);                     expect_now("ar_reload", 0, 0, 0, 2, 1, 1);
        idle(1);                     expect_now("ar_after", 0, 0, 0, 1, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);  expect_now("ar_zero", 0, 0, 0, 0, 0, 0);
`endif

        drive(1, 0, 0, 0, 63, 60, 1023); expect_now("clamp", 0, 59, 59, 999, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        idle(5);                         expect_now("run5", 0, 59, 59, 994, 1, 0);
        repeat (10) drive(0, 0, 1, 0, 0, 0, 0);
        expect_now("paused", 0, 59, 59, 994, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);      expect_now("resume", 0, 59, 59, 994, 1, 0);
        idle(1);                         expect_now("resumed", 0, 59, 59, 993, 1, 0);

        drive(1, 1, 1, 0, 1, 2, 3);      expect_now("prio_load", 0, 1, 2, 3, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        idle(1);                         expect_now("prio_run", 0, 1, 2, 2, 1, 0);
        drive(0, 1, 1, 0, 0, 0, 0);      expect_now("prio_stop", 0, 1, 2, 2, 0, 0);

        drive(1, 0, 0, 0, 0, 5, 500);
        drive(0, 1, 0, 0, 0, 0, 0);      expect_now("pre_rst", 0, 0, 5, 500, 1, 0);
        rst = 1'b1;
        #1;
        expect_now("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 20000; i++) begin
            r  = $urandom_range(0, 99);
            ld = (r < 3);
            sp = ($urandom_range(0, 99) < 6);
            st = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 3) == 0) begin
                h  = $urandom_range(0, 15);
                m  = $urandom_range(0, 63);
                s  = $urandom_range(0, 63);
                ms = $urandom_range(0, 1023);
            end else begin
                h  = 0;
                m  = 0;
                s  = $urandom_range(0, 1);
                ms = $urandom_range(0, 999);
            end
            drive(ld, st, sp, h, m, s, ms);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
